// File: rtl/router_in_ctrl.sv
// router_in_ctrl: header decode and byte steering from the source into NUM_PORTS FIFOs.
// Define ROUTER_IN_STATS_EN to add saturating packet/error/drop counters.
module router_in_ctrl #(
  parameter int NUM_PORTS = 3
`ifdef ROUTER_IN_STATS_EN
  , parameter int STAT_W = 16
`endif
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic [7:0]           din,
  input  logic                 pkt_valid,
  input  logic [NUM_PORTS-1:0] fifo_full,
  output logic                 busy,
  output logic                 error,
  output logic [7:0]           dout,
  output logic [NUM_PORTS-1:0] write_enb
`ifdef ROUTER_IN_STATS_EN
  , output logic [STAT_W-1:0]  pkt_count,
  output logic [STAT_W-1:0]    err_count,
  output logic [STAT_W-1:0]    drop_count
`endif
);
  typedef enum logic [2:0] {IDLE, LOAD_DATA, LOAD_PARITY, CHECK, DROP} state_t;
  state_t st, st_d;
  logic [1:0] addr_q, wport;
  logic [5:0] len_q, cnt_q;
  logic [7:0] par_q;
  logic       par_ok, len_err, wr, valid_addr, hdr_full, cur_full;
  logic [3:0] full_ext, we4;
  // fifo_full widened to the 2-bit address space so invalid addresses index safely
  always_comb begin
    full_ext = '0;
    full_ext[NUM_PORTS-1:0] = fifo_full;
  end
  assign valid_addr = 32'(din[1:0]) < NUM_PORTS;
  assign hdr_full   = full_ext[din[1:0]];
  assign cur_full   = full_ext[addr_q];
  assign dout       = din;
  assign we4        = wr ? 4'b0001 << wport : 4'b0000;
  assign write_enb  = we4[NUM_PORTS-1:0];
  always_comb begin
    st_d  = st;
    busy  = 1'b0;
    wr    = 1'b0;
    wport = addr_q;
    case (st)
      IDLE: begin
        busy = pkt_valid & valid_addr & hdr_full;
        if (pkt_valid & valid_addr & !hdr_full) begin
          wr    = 1'b1;
          wport = din[1:0];
          st_d  = din[7:2] == 6'd0 ? LOAD_PARITY : LOAD_DATA;
        end else if (pkt_valid & !valid_addr) st_d = DROP;
      end
      LOAD_DATA: begin
        busy = cur_full;
        if (!cur_full) begin
          wr   = 1'b1;
          st_d = !pkt_valid ? CHECK : (cnt_q + 6'd1 == len_q) ? LOAD_PARITY : LOAD_DATA;
        end
      end
      LOAD_PARITY: begin
        busy = cur_full;
        if (!cur_full) begin
          wr   = 1'b1;
          st_d = CHECK;
        end
      end
      CHECK: begin
        busy = 1'b1;
        st_d = IDLE;
      end
      DROP: st_d = pkt_valid ? DROP : IDLE;
      default: st_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      st      <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      par_q   <= '0;
      par_ok  <= 1'b1;
      len_err <= 1'b0;
      error   <= 1'b0;
    end else begin
      st <= st_d;
      if (st == IDLE && wr) begin
        addr_q  <= din[1:0];
        len_q   <= din[7:2];
        cnt_q   <= '0;
        par_q   <= din;
        par_ok  <= 1'b1;
        len_err <= 1'b0;
        error   <= 1'b0;
      end
      if (st == LOAD_DATA && wr) begin
        if (pkt_valid) begin
          par_q <= par_q ^ din;
          cnt_q <= cnt_q + 6'd1;
        end else begin
          par_ok  <= din == par_q;
          len_err <= 1'b1;
        end
      end
      // a still-high pkt_valid on the parity byte means the packet ran long
      if (st == LOAD_PARITY && wr) begin
        par_ok  <= din == par_q;
        len_err <= len_err | pkt_valid;
      end
      if (st == CHECK) error <= ~par_ok | len_err;
    end
  end
`ifdef ROUTER_IN_STATS_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pkt_count  <= '0;
      err_count  <= '0;
      drop_count <= '0;
    end else begin
      if (st == CHECK) pkt_count <= pkt_count + STAT_W'(~&pkt_count);
      if (st == CHECK && (~par_ok | len_err)) err_count <= err_count + STAT_W'(~&err_count);
      if (st == DROP && !pkt_valid) drop_count <= drop_count + STAT_W'(~&drop_count);
    end
  end
`endif
endmodule

// File: tb/tb_router_in_ctrl.sv
// tb_router_in_ctrl: directed packets; expected FIFO writes queued and checked by a negedge monitor.
module tb_router_in_ctrl;
  logic       clock, resetn, pkt_valid, busy, error;
  logic [7:0] din, dout;
  logic [2:0] fifo_full, write_enb;
`ifdef ROUTER_IN_STATS_EN
  logic [15:0] pkt_count, err_count, drop_count;
`endif
  int tests = 0, fails = 0, busy_n = 0, wr_n = 0, b0, w0;
  logic [10:0] exp_q[$];
  logic [7:0]  p;

  router_in_ctrl dut (
    .clock(clock), .resetn(resetn), .din(din), .pkt_valid(pkt_valid),
    .fifo_full(fifo_full), .busy(busy), .error(error), .dout(dout),
    .write_enb(write_enb)
`ifdef ROUTER_IN_STATS_EN
    , .pkt_count(pkt_count), .err_count(err_count), .drop_count(drop_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic tx(input logic [7:0] d, input logic v, input int port);
    din = d;
    pkt_valid = v;
    if (port >= 0) exp_q.push_back({3'(1 << port), d});
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    tx(8'h00, 1'b0, -1);
  endtask

  always @(negedge clock) begin
    if (resetn) begin
      if (busy) busy_n++;
      if (write_enb != 3'b000) begin
        wr_n++;
        if (exp_q.size() == 0) chk("unexpected_write", {21'b0, write_enb, dout}, 32'h0);
        else chk("write", {21'b0, write_enb, dout}, {21'b0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    resetn = 1'b0; din = 8'h00; pkt_valid = 1'b0; fifo_full = 3'b000;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_error", {31'b0, error}, 0);
    chk("rst_we", {29'b0, write_enb}, 0);
    resetn = 1'b1;
    idle();
    // good packet, non-selected FIFOs full
    b0 = busy_n; w0 = wr_n; fifo_full = 3'b101;
    tx(8'h0D, 1, 1); tx(8'h11, 1, 1); tx(8'h22, 1, 1); tx(8'h33, 1, 1); tx(8'h0D, 0, 1);
    chk("good_check_busy", {31'b0, busy}, 1);
    idle();
    chk("good_busy_cycles", busy_n - b0, 1);
    chk("good_writes", wr_n - w0, 5);
    chk("good_error", {31'b0, error}, 0);
    // back-pressure on port 1 for 3 cycles
    b0 = busy_n; w0 = wr_n; fifo_full = 3'b000;
    tx(8'h0D, 1, 1); tx(8'h11, 1, 1);
    fifo_full = 3'b010;
    repeat (3) tx(8'h22, 1, -1);
    fifo_full = 3'b000;
    tx(8'h22, 1, 1); tx(8'h33, 1, 1); tx(8'h0D, 0, 1);
    idle();
    chk("bp_busy_cycles", busy_n - b0, 4);
    chk("bp_writes", wr_n - w0, 5);
    chk("bp_error", {31'b0, error}, 0);
    // parity error, held, cleared by next accepted header
    tx(8'h0D, 1, 1); tx(8'h11, 1, 1); tx(8'h22, 1, 1); tx(8'h33, 1, 1); tx(8'h0C, 0, 1);
    idle();
    chk("par_error", {31'b0, error}, 1);
    idle(); idle();
    din = 8'h04; pkt_valid = 1'b1;
    chk("par_error_held", {31'b0, error}, 1);
    tx(8'h04, 1, 0);
    chk("hdr_clears_error", {31'b0, error}, 0);
    tx(8'h55, 1, 0); tx(8'h51, 0, 0);
    idle();
    chk("len1_error", {31'b0, error}, 0);
    // invalid address dropped
    b0 = busy_n; w0 = wr_n;
    tx(8'h0B, 1, -1); tx(8'hAA, 1, -1); tx(8'hBB, 1, -1); tx(8'hCC, 0, -1);
    idle();
    chk("drop_busy", busy_n - b0, 0);
    chk("drop_writes", wr_n - w0, 0);
    chk("drop_error", {31'b0, error}, 0);
`ifdef ROUTER_IN_STATS_EN
    chk("drop_count", {16'b0, drop_count}, 1);
`endif
    // zero length
    w0 = wr_n;
    tx(8'h00, 1, 0); tx(8'h00, 0, 0);
    idle();
    chk("zlen_writes", wr_n - w0, 2);
    chk("zlen_error", {31'b0, error}, 0);
    // overlong: pkt_valid still high on parity byte
    tx(8'h05, 1, 1); tx(8'h10, 1, 1); tx(8'h15, 1, 1);
    idle();
    chk("overlong_error", {31'b0, error}, 1);
    // maximum length 63 to port 2
    w0 = wr_n; p = 8'hFE;
    tx(8'hFE, 1, 2);
    for (int i = 1; i <= 63; i++) begin
      tx(8'(i), 1, 2);
      p = p ^ 8'(i);
    end
    tx(p, 0, 2);
    idle();
    chk("len63_writes", wr_n - w0, 65);
    chk("len63_error", {31'b0, error}, 0);
    // short packet: parity arrives after one of three payload bytes
    tx(8'h0C, 1, 0); tx(8'hAA, 1, 0); tx(8'h77, 0, 0);
    idle();
    chk("short_error", {31'b0, error}, 1);
    // asynchronous reset mid-packet
    tx(8'h0D, 1, 1); tx(8'h11, 1, 1); tx(8'h22, 1, 1);
    din = 8'h33; pkt_valid = 1'b1;
    resetn = 1'b0;
    #1;
    chk("midrst_we", {29'b0, write_enb}, 0);
    chk("midrst_busy", {31'b0, busy}, 0);
    chk("midrst_error", {31'b0, error}, 0);
    pkt_valid = 1'b0;
    @(posedge clock);
    #1;
    resetn = 1'b1;
    idle();
    w0 = wr_n;
    tx(8'h0E, 1, 2); tx(8'h01, 1, 2); tx(8'h02, 1, 2); tx(8'h03, 1, 2); tx(8'h0E, 0, 2);
    idle();
    chk("post_rst_writes", wr_n - w0, 5);
    chk("post_rst_error", {31'b0, error}, 0);
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/router_in_ctrl.md
Name: router_in_ctrl

Overview:
Input controller of the router 1x3, directly downstream of the source-side packet interface.
- Accepts byte-serial packets on din/pkt_valid and decodes the header (din[1:0] = destination port, din[7:2] = payload length).
- Steers header, payload and parity bytes into one of three output FIFOs.
- Back-pressures the source with busy and reports parity or length errors on error.

Parameters:
NUM_PORTS, 3, number of destination FIFOs; address value NUM_PORTS and above is invalid (3 with default)
STAT_W, 16, width of statistics counters (used only with ROUTER_IN_STATS_EN)

Ports:
clock  input  1  single clock, all logic on posedge
resetn  input  1  asynchronous, active-low reset
din  input  8  packet byte from source
pkt_valid  input  1  high for header and payload bytes, low on the parity byte
fifo_full  input  NUM_PORTS  full flag per destination FIFO
busy  output  1  source must hold din/pkt_valid while high
error  output  1  registered packet error flag
dout  output  8  byte to FIFOs, equal to din (combinational)
write_enb  output  NUM_PORTS  one-hot write strobe, at most one bit high

Behaviour:
Reset:
- state=IDLE, addr_q=0, len_q=0, cnt_q=0, par_q=0, error=0.
- write_enb=0 and busy=0 during and after reset.
- Reset mid-packet is asynchronous: return to IDLE immediately; any partial packet already in a FIFO is not recovered.

A byte is "accepted" in a cycle when the state's accept condition holds; it is written that same cycle (zero latency).

IDLE:
- busy = pkt_valid & valid_addr & fifo_full[din[1:0]].
- Accept when pkt_valid & valid_addr & !fifo_full[din[1:0]]:
  - write_enb[din[1:0]]=1, latch addr_q=din[1:0], len_q=din[7:2], cnt_q=0, par_q=din, clear error.
  - Go to LOAD_DATA, or LOAD_PARITY if len=0.
- pkt_valid & invalid addr: go to DROP; nothing written; error unchanged.
- pkt_valid=0: no action.

LOAD_DATA:
- busy=fifo_full[addr_q].
- Accept when pkt_valid & !busy: write byte, par_q^=din, cnt_q++; go to LOAD_PARITY when cnt_q+1==len_q.
- pkt_valid=0 & !busy (early parity):
  - Write the byte as the parity byte.
  - Set len_err, go to CHECK.

LOAD_PARITY:
- busy=fifo_full[addr_q].
- When !busy: write byte, latch par_ok=(din==par_q), go to CHECK.
- pkt_valid=1 here (overlong packet): byte still written as parity; set len_err.

CHECK:
- One cycle, busy=1, write_enb=0.
- error <= ~par_ok | len_err; then go to IDLE.

DROP:
- busy=0, write_enb=0.
- Consume bytes while pkt_valid=1.
- The first cycle with pkt_valid=0 consumes the parity byte; return to IDLE.

Error:
- Holds its value until the next accepted header clears it.
- Header accept and error clear happen in the same cycle.

Simultaneous events:
- fifo_full rising on the same edge as a would-be accept blocks that accept; the byte is retried.
- fifo_full for non-selected ports is ignored.

Arithmetic:
- par_q is the 8-bit XOR of header and payload bytes.
- cnt_q and len_q are 6 bits; len 63 is the maximum, with no wrap.

Optional Feature:
Macro ROUTER_IN_STATS_EN.
- Defined:
  - Adds outputs pkt_count[STAT_W-1:0], err_count[STAT_W-1:0] and drop_count[STAT_W-1:0], all reset to 0.
  - Each increments on CHECK completion, on error set, or on DROP exit respectively; each saturates at all-ones.
- Not defined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Good packet: din 0x0D (addr1, len3), 0x11, 0x22, 0x33 with pkt_valid=1, then 0x0D with pkt_valid=0 -> write_enb=3'b010 for 5 consecutive cycles, then busy=1 for 1 cycle, error=0.
- Back-pressure: same packet, fifo_full[1]=1 for 3 cycles while din=0x22 -> busy=1 for exactly 3 cycles, no write_enb, 0x22 written once after release, error=0.
- Parity error: same packet with final byte 0x0C -> error=1 from the cycle after CHECK and held; next header 0x04 clears error the cycle it is accepted.
- Invalid address: header 0x0B, two payload bytes, parity -> write_enb never set, busy=0 throughout, back in IDLE; drop_count=1 if ROUTER_IN_STATS_EN.
- Zero length: header 0x00 then parity 0x00 (pkt_valid=0) -> two writes to port 0, error=0; header 0x0C (addr0, len3) followed by pkt_valid=0 after one payload -> error=1 (length).
- Reset mid-packet: drop resetn after second payload byte -> write_enb=0 and busy=0 immediately; next header 0x0E (addr2, len3) accepted normally to port 2.
